// File: rtl/axi_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : axi_uart_tx
// Brief    : AXI4-Lite slave UART transmitter. Bytes written to TXDATA queue
//            in a small FIFO and are serialised LSB first at a fixed baud
//            rate (8N1, or 8E1 when AXI_UART_TX_PARITY_EN is defined).
//            Register map: 0x0 TXDATA (write-only), 0x4 STATUS (read-only,
//            bit0 full, bit1 empty, bit2 busy).
// Revision : 1.0 - initial release
// ============================================================================
module axi_uart_tx #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int UART_BAUD_RATE  = 57600,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // write address
  input  logic        s_awvalid_i,
  output logic        s_awready_o,
  input  logic [31:0] s_awaddr_i,
  // write data
  input  logic        s_wvalid_i,
  output logic        s_wready_o,
  input  logic [31:0] s_wdata_i,
  input  logic [3:0]  s_wstrb_i,
  // write response
  output logic        s_bvalid_o,
  input  logic        s_bready_i,
  output logic [1:0]  s_bresp_o,
  // read address
  input  logic        s_arvalid_i,
  output logic        s_arready_o,
  input  logic [31:0] s_araddr_i,
  // read data
  output logic        s_rvalid_o,
  input  logic        s_rready_i,
  output logic [31:0] s_rdata_o,
  output logic [1:0]  s_rresp_o,
  // serial line
  output logic        tx_o
);

  localparam int DIV   = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef AXI_UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  // FIFO storage and pointers (one extra bit distinguishes full from empty)
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  head;

  // transmitter state
  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             baud_done;
  logic             busy;
`ifdef AXI_UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // bus-side decode
  logic        wr_to_data;
  logic        wr_fire;
  logic        push;
  logic        pop;
  logic        rd_fire;
  logic [31:0] status_word;
  logic        unused_inputs;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  assign busy      = (state != ST_IDLE);
  assign baud_done = (baud_cnt == BAUD_LAST);

  // AW and W are taken together; a TXDATA write to a full FIFO waits rather
  // than being dropped, and a pending B response blocks the next write.
  assign wr_to_data  = (s_awaddr_i[3:0] == OFF_TXDATA);
  assign wr_fire     = s_awvalid_i & s_wvalid_i & ~s_bvalid_o & ~(wr_to_data & fifo_full);
  assign s_awready_o = wr_fire;
  assign s_wready_o  = wr_fire;
  assign push        = wr_fire & wr_to_data & s_wstrb_i[0];

  // The head byte leaves the FIFO when a frame starts: from IDLE, or straight
  // out of STOP so back-to-back frames have no idle gap.
  assign pop = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_done));

  assign s_arready_o = ~s_rvalid_o;
  assign rd_fire     = s_arvalid_i & ~s_rvalid_o;
  assign status_word = {29'd0, busy, fifo_empty, fifo_full};

  assign unused_inputs = ^{s_awaddr_i[31:4], s_wdata_i[31:8], s_wstrb_i[3:1], s_araddr_i[31:4]};

  // FIFO data store; contents need no reset because the pointers gate them
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s_wdata_i[7:0];
    end
  end

  // FIFO pointer update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write response: raised after the AW/W handshake, held until accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_bvalid_o <= 1'b0;
      s_bresp_o  <= RESP_OKAY;
    end else if (wr_fire) begin
      s_bvalid_o <= 1'b1;
      s_bresp_o  <= wr_to_data ? RESP_OKAY : RESP_SLVERR;
    end else if (s_bready_i) begin
      s_bvalid_o <= 1'b0;
    end
  end

  // Read channel: data is sampled on the AR handshake and held until taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_rvalid_o <= 1'b0;
      s_rdata_o  <= '0;
      s_rresp_o  <= RESP_OKAY;
    end else if (rd_fire) begin
      s_rvalid_o <= 1'b1;
      case (s_araddr_i[3:0])
        OFF_TXDATA: begin
          s_rdata_o <= '0;
          s_rresp_o <= RESP_OKAY;
        end
        OFF_STATUS: begin
          s_rdata_o <= status_word;
          s_rresp_o <= RESP_OKAY;
        end
        default: begin
          s_rdata_o <= '0;
          s_rresp_o <= RESP_SLVERR;
        end
      endcase
    end else if (s_rready_i) begin
      s_rvalid_o <= 1'b0;
    end
  end

  // Transmit FSM; tx_o is registered and updated on the same edge that enters
  // each bit so every bit on the line lasts exactly DIV cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      tx_o       <= 1'b1;
`ifdef AXI_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      if (!fifo_empty) begin
        state      <= ST_START;
        shift_reg  <= head;
        baud_cnt   <= '0;
        tx_o       <= 1'b0;
`ifdef AXI_UART_TX_PARITY_EN
        parity_bit <= ^head;
`endif
      end
    end else if (!baud_done) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      case (state)
        ST_START: begin
          state   <= ST_DATA;
          bit_cnt <= '0;
          tx_o    <= shift_reg[0];
        end
        ST_DATA: begin
          if (bit_cnt == 3'd7) begin
`ifdef AXI_UART_TX_PARITY_EN
            state <= ST_PARITY;
            tx_o  <= parity_bit;
`else
            state <= ST_STOP;
            tx_o  <= 1'b1;
`endif
          end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            shift_reg <= {1'b0, shift_reg[7:1]};
            tx_o      <= shift_reg[1];
          end
        end
`ifdef AXI_UART_TX_PARITY_EN
        ST_PARITY: begin
          state <= ST_STOP;
          tx_o  <= 1'b1;
        end
`endif
        ST_STOP: begin
          if (!fifo_empty) begin
            state      <= ST_START;
            shift_reg  <= head;
            tx_o       <= 1'b0;
`ifdef AXI_UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
          end else begin
            state <= ST_IDLE;
            tx_o  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_uart_tx
// Brief    : Self-checking bench for axi_uart_tx. A line monitor records every
//            frame seen on tx_o; a queue-based model predicts byte order and
//            frame start cycles from the write handshake times.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_uart_tx;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 7_500_000;
  localparam int DIV    = CLK_HZ / BAUD;   // truncates to 13
  localparam int DEPTH  = 8;
`ifdef AXI_UART_TX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  localparam int FRAME  = NBITS * DIV;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_awvalid_i = 1'b0, s_wvalid_i = 1'b0, s_bready_i = 1'b1;
  logic        s_arvalid_i = 1'b0, s_rready_i = 1'b1;
  logic [31:0] s_awaddr_i = '0, s_wdata_i = '0, s_araddr_i = '0;
  logic [3:0]  s_wstrb_i = '0;
  logic        s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o, tx_o;
  logic [1:0]  s_bresp_o, s_rresp_o;
  logic [31:0] s_rdata_o;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  axi_uart_tx #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .UART_BAUD_RATE (BAUD),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
    .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
    .tx_o(tx_o)
  );

  initial forever #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] b; int start; } exp_t;
  typedef struct { int start; logic [10:0] first; logic [10:0] last; } frame_t;
  exp_t   exp_q[$];
  frame_t mon_q[$];
  int     line_free = 0;   // cycle at which the line finishes its last predicted frame

  // Expected line levels, index 0 = start bit
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] v = '0;
    v[8:1] = b;
`ifdef AXI_UART_TX_PARITY_EN
    v[9]  = ^b;
    v[10] = 1'b1;
`else
    v[9]  = 1'b1;
`endif
    return v;
  endfunction

  // Line monitor: samples the first and last cycle of every bit of each frame
  initial begin : line_monitor
    frame_t f;
    bit     active = 1'b0;
    int     off = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        active = 1'b0;
      end else begin
        if (!active && tx_o === 1'b0) begin
          active = 1'b1; off = 0; f.start = cyc; f.first = '0; f.last = '0;
        end
        if (active) begin
          if (off % DIV == 0)       f.first[off / DIV] = tx_o;
          if (off % DIV == DIV - 1) f.last[off / DIV]  = tx_o;
          if (off == FRAME - 1) begin
            mon_q.push_back(f);
            active = 1'b0;
          end else begin
            off++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bus drivers (called on a falling edge) ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int hs);
    int n = 0;
    int st;
    s_awaddr_i = addr; s_wdata_i = data; s_wstrb_i = strb;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    #1;
    while (s_awready_o !== 1'b1 && n < 4 * FRAME * DEPTH) begin
      @(negedge clk_i); #1; n++;
    end
    if (s_awready_o !== 1'b1) begin
      tests++; errors++;
      $display("FAIL write_timeout addr=%h awready=%b", addr, s_awready_o);
      s_awvalid_i = 1'b0; s_wvalid_i = 1'b0; resp = 2'bxx; hs = -1;
      return;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    hs = cyc;
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    resp = (s_bvalid_o === 1'b1) ? s_bresp_o : 2'bxx;
    if (addr[3:0] == 4'h0 && strb[0]) begin
      st = (hs + 1 > line_free) ? hs + 1 : line_free;
      exp_q.push_back('{data[7:0], st});
      line_free = st + FRAME;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    s_araddr_i = addr; s_arvalid_i = 1'b1;
    #1;
    while (s_arready_o !== 1'b1 && n < 1000) begin
      @(negedge clk_i); #1; n++;
    end
    if (s_arready_o !== 1'b1) begin
      tests++; errors++;
      $display("FAIL read_timeout addr=%h arready=%b", addr, s_arready_o);
      s_arvalid_i = 1'b0; data = 'x; resp = 'x;
      return;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    s_arvalid_i = 1'b0;
    data = (s_rvalid_o === 1'b1) ? s_rdata_o : 'x;
    resp = (s_rvalid_o === 1'b1) ? s_rresp_o : 2'bxx;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    tests++;
    if ({tx_o, s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o} !== 6'b100100) begin
      errors++;
      $display("FAIL reset_ctrl got tx/aw/w/ar/b/r=%b want 100100",
               {tx_o, s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o});
    end
    tests++;
    if ({s_bresp_o, s_rresp_o, s_rdata_o} !== 36'd0) begin
      errors++;
      $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h want 0", s_bresp_o, s_rresp_o, s_rdata_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h2 || r !== 2'b00) begin
      errors++; $display("FAIL reset_status got %h/%b want 00000002/00", d, r);
    end
  endtask

  task automatic test_single_write();
    logic [31:0] d; logic [1:0] r; int hs;
    axi_write(32'h0, 32'h41, 4'hF, r, hs);
    tests++;
    if (r !== 2'b00) begin errors++; $display("FAIL single_bresp got %b want 00", r); end
    tests++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL single_tx_before got %b want 1", tx_o); end
    @(negedge clk_i);
    tests++;
    if (tx_o !== 1'b0) begin errors++; $display("FAIL single_tx_fall got %b want 0", tx_o); end
    repeat (2 * DIV) @(negedge clk_i);
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h6 || r !== 2'b00) begin
      errors++; $display("FAIL status_busy_empty got %h/%b want 00000006/00", d, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; int hs[10]; int first; int predicted; int bad = 0;
    while (cyc < line_free + 2) @(negedge clk_i);
    first = exp_q.size();
    for (int i = 0; i < 9; i++) begin
      axi_write(32'h0, 32'h30 + i, 4'hF, r, hs[i]);
      if (r !== 2'b00) bad++;
    end
    tests++;
    if (bad != 0) begin errors++; $display("FAIL b2b_bresp got %0d bad responses want 0", bad); end
    tests++;
    if (hs[8] != hs[0] + 16) begin
      errors++; $display("FAIL b2b_throughput got %0d cycles want 16", hs[8] - hs[0]);
    end
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h5) begin errors++; $display("FAIL status_full_busy got %h want 00000005", d); end
    // With 8 bytes queued, the next write waits for the second frame's pop.
    predicted = exp_q[first + 1].start + 1;
    axi_write(32'h0, 32'h39, 4'hF, r, hs[9]);
    tests++;
    if (hs[9] != predicted) begin
      errors++; $display("FAIL b2b_stall got handshake %0d want %0d", hs[9], predicted);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r; int hs;
    while (cyc < line_free + 2) @(negedge clk_i);
    axi_write(32'h8, $urandom, 4'hF, r, hs);
    tests++;
    if (r !== 2'b10) begin errors++; $display("FAIL bad_addr_bresp got %b want 10", r); end
    axi_write(32'h0, 32'h5A, 4'b0000, r, hs);
    tests++;
    if (r !== 2'b00) begin errors++; $display("FAIL strb0_bresp got %b want 00", r); end
    axi_read(32'hC, d, r);
    tests++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL bad_addr_read got %h/%b want 0/10", d, r); end
    axi_read(32'h0, d, r);
    tests++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL txdata_read got %h/%b want 0/00", d, r); end
    repeat (3) @(negedge clk_i);
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h2) begin errors++; $display("FAIL no_push_status got %h want 00000002", d); end
  endtask

  task automatic test_bready_hold();
    logic [1:0] r; int hs;
    s_bready_i = 1'b0;
    axi_write(32'h8, 32'h0, 4'hF, r, hs);
    tests++;
    if (r !== 2'b10) begin errors++; $display("FAIL hold_bresp got %b want 10", r); end
    s_awaddr_i = 32'h8; s_wdata_i = 32'h0; s_wstrb_i = 4'hF;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #1;
      tests++;
      if (s_bvalid_o !== 1'b1 || s_awready_o !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d got bvalid=%b awready=%b want 1/0", i, s_bvalid_o, s_awready_o);
      end
    end
    @(negedge clk_i);
    s_bready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i); #1;
    tests++;
    if (s_bvalid_o !== 1'b0 || s_awready_o !== 1'b1 || s_wready_o !== 1'b1) begin
      errors++; $display("FAIL hold_release got bvalid=%b awready=%b wready=%b want 0/1/1",
                         s_bvalid_o, s_awready_o, s_wready_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    tests++;
    if (s_bvalid_o !== 1'b1 || s_bresp_o !== 2'b10) begin
      errors++; $display("FAIL hold_next_write got bvalid=%b bresp=%b want 1/10", s_bvalid_o, s_bresp_o);
    end
  endtask

  task automatic test_random();
    logic [1:0] r; int hs; int bad = 0;
    axi_write(32'h0, 32'h43, 4'h1, r, hs);
    if (r !== 2'b00) bad++;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk_i);
      axi_write({$urandom_range(0, 15), 4'h0}, $urandom, 4'($urandom_range(0, 15)), r, hs);
      if (r !== 2'b00) bad++;
    end
    tests++;
    if (bad != 0) begin errors++; $display("FAIL random_bresp got %0d bad responses want 0", bad); end
  endtask

  task automatic test_line_frames();
    exp_t e; frame_t f;
    while (cyc < line_free + 4) @(negedge clk_i);
    tests++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL frame_count got %0d want %0d", mon_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      e = exp_q.pop_front();
      f = mon_q.pop_front();
      tests++;
      if (f.start != e.start) begin
        errors++; $display("FAIL frame_start byte=%h got %0d want %0d", e.b, f.start, e.start);
      end
      tests++;
      if (f.first !== frame_bits(e.b) || f.last !== frame_bits(e.b)) begin
        errors++; $display("FAIL frame_bits byte=%h got first=%b last=%b want %b",
                           e.b, f.first, f.last, frame_bits(e.b));
      end
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d; logic [1:0] r; int hs; int target;
    while (cyc < line_free + 2) @(negedge clk_i);
    axi_write(32'h0, 32'h41, 4'h1, r, hs);
    axi_write(32'h0, 32'h55, 4'h1, r, hs);
    // bit index 3 of the frame is data bit 2 of 0x41, a zero
    target = exp_q[0].start + 3 * DIV + 4;
    while (cyc < target) @(negedge clk_i);
    tests++;
    if (tx_o !== 1'b0) begin errors++; $display("FAIL pre_reset_tx got %b want 0", tx_o); end
    #2 rst_ni = 1'b0;
    #1;
    tests++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL async_reset_tx got %b want 1", tx_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    exp_q.delete();
    line_free = 0;
    @(negedge clk_i);
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h2) begin errors++; $display("FAIL post_reset_status got %h want 00000002", d); end
    repeat (3 * FRAME) @(negedge clk_i);
    tests++;
    if (mon_q.size() != 0 || tx_o !== 1'b1) begin
      errors++; $display("FAIL post_reset_line got %0d frames tx=%b want 0 frames tx=1", mon_q.size(), tx_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_errors();
    test_bready_hold();
    test_random();
    test_line_frames();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
